// File: rtl/fmac_pkg.sv
// FMAC shared definitions: divider widths,
// iteration count and control-state encoding.
package fmac_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int DIV_ITERS  = 16;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring-division iteration on
// unsigned magnitudes (purely combinational).
module div_step
  import fmac_pkg::*;
(
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] dvs_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_o
);

  logic [DIVISOR_W:0]   sh;
  logic [DIVISOR_W+1:0] diff;

  // shift in next bit, trial-subtract, restore on borrow
  always_comb begin
    sh    = {rem_i[DIVISOR_W-1:0], bit_i};
    diff  = {1'b0, sh} - {2'b00, dvs_i};
    // a set top bit means the shifted value
    // exceeds any 8-bit divisor: always subtract
    q_o   = ~diff[DIVISOR_W+1] | rem_i[DIVISOR_W];
    rem_o = q_o ? diff[DIVISOR_W:0] : sh;
  end

endmodule

// File: rtl/sequential_divider.sv
// Iterative signed 16/8 divider: magnitudes,
// 16 restoring steps, then sign fix/saturate.
module sequential_divider
  import fmac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  overflow,
  output logic                  divByZero
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DIV_ITERS - 1);

  div_state_e state_q, state_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  lo_q, lo_d;
  logic                  sa_q, sa_d;
  logic                  sb_q, sb_d;
  logic                  zero_q, zero_d;
  logic [DIVISOR_W-1:0]  quot_q, quot_d;
  logic [DIVISOR_W-1:0]  remo_q, remo_d;
  logic                  ovf_q, ovf_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic [DIVISOR_W-1:0]  q_lo;
  logic [DIVISOR_W-1:0]  r_mag;

  div_step u_step (
    .rem_i (rem_q),
    .bit_i (q_q[DIVIDEND_W-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs, registered from next state
  always_comb begin
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // operand capture, iteration and sign fix
  always_comb begin
    dvd_mag = dividend[DIVIDEND_W-1] ?
              -dividend : dividend;
    dvs_mag = divisor[DIVISOR_W-1] ?
              -divisor : divisor;
    q_lo    = q_q[DIVISOR_W-1:0];
    r_mag   = rem_q[DIVISOR_W-1:0];
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: if (start) begin
        cnt_d  = '0;
        rem_d  = '0;
        q_d    = dvd_mag;
        dvs_d  = dvs_mag;
        lo_d   = dividend[DIVISOR_W-1:0];
        sa_d   = dividend[DIVIDEND_W-1];
        sb_d   = divisor[DIVISOR_W-1];
        zero_d = (divisor == '0);
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = step_rem;
        q_d   = {q_q[DIVIDEND_W-2:0], step_q};
      end
      FIX: begin
        ovf_d  = 1'b0;
        dbz_d  = zero_q;
        remo_d = sa_q ? -r_mag : r_mag;
        if (zero_q) begin
          quot_d = '0;
          remo_d = lo_q;
        end else if (sa_q ^ sb_q) begin
          if (q_q > 16'd128) begin
            ovf_d  = 1'b1;
            quot_d = 8'h80;
          end else begin
            quot_d = -q_lo;
          end
        end else begin
          if (q_q > 16'd127) begin
            ovf_d  = 1'b1;
            quot_d = 8'h7F;
          end else begin
            quot_d = q_lo;
          end
        end
      end
      default: ;
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      dvs_q  <= '0;
      lo_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      zero_q <= 1'b0;
      quot_q <= '0;
      remo_q <= '0;
      ovf_q  <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      q_q    <= q_d;
      dvs_q  <= dvs_d;
      lo_q   <= lo_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      zero_q <= zero_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
      ovf_q  <= ovf_d;
      dbz_q  <= dbz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign overflow  = ovf_q;
  assign divByZero = dbz_q;

endmodule
